// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Start/complete responder for the execution unit divide path.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             complete,
  output logic             divide_by_0,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    t     = {r[WIDTH-1:0], q[WIDTH-1]};
    ge    = t >= {1'b0, d};
    r_nxt = ge ? t - {1'b0, d} : t;
    q_nxt = {q[WIDTH-2:0], ge};
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      complete    <= 1'b0;
      divide_by_0 <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (start) begin
      // A new request always wins over whatever is in flight.
      if (b != '0) begin
        state       <= BUSY;
        r           <= '0;
        q           <= a;
        d           <= b;
        cnt         <= '0;
        complete    <= 1'b0;
        divide_by_0 <= 1'b0;
      end else begin
        state       <= DONE;
        complete    <= 1'b1;
        divide_by_0 <= 1'b1;
        quotient    <= '1;
        remainder   <= a;
      end
    end else if (state == BUSY && !hold) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state       <= DONE;
        quotient    <= q_nxt;
        remainder   <= r_nxt[WIDTH-1:0];
        complete    <= 1'b1;
        divide_by_0 <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider: the responder side of the execution unit's start/complete divide handshake. The execution unit pre-negates signed operands and fixes up result signs itself. It issues `start` with magnitude operands and waits for `complete`. It then reads `quotient`, `remainder` and `divide_by_0`. One instance sits inside each execution unit; its reset is the unit's `rst || branch_mispredict`.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset. Also used as the mispredict flush.
- `start` input 1: begin a division. Sampled at the rising edge.
- `hold` input 1: freezes iteration while in BUSY. Tied 0 in current use but must work.
- `a` input WIDTH: dividend, unsigned. Sampled only on the `start` edge.
- `b` input WIDTH: divisor, unsigned. Sampled only on the `start` edge.
- `busy` output 1: high while state is BUSY.
- `complete` output 1: result valid. Stays high until the next `start` or `rst`.
- `divide_by_0` output 1: the last accepted `b` was 0. Valid while `complete` is high.
- `quotient` output WIDTH: registered result.
- `remainder` output WIDTH: registered result.

## Operation
- States:
  - IDLE: after reset, nothing ever run.
  - BUSY: iterating.
  - DONE: result presented.
- Internal registers:
  - working remainder `r`, WIDTH+1 bits
  - working dividend/quotient shift register `q`, WIDTH bits
  - latched divisor `d`
  - iteration counter `cnt`, $clog2(WIDTH)+1 bits
- `start` is accepted in every state, including BUSY and DONE. Any operation in progress is discarded and its result is never presented.
- On accept with `b != 0`:
  - Load `r`=0, `q`=`a`, `d`=`b`, `cnt`=0.
  - Go to BUSY; `complete` and `divide_by_0` go to 0.
- On accept with `b == 0`:
  - Go directly to DONE with `complete`=1, `divide_by_0`=1.
  - Outputs `quotient`={WIDTH{1'b1}}, `remainder`=`a`.
- Each BUSY edge with `hold`=0 performs one restoring step:
  - `t` = {`r`[WIDTH-1:0], `q`[WIDTH-1]}.
  - If `t` >= {1'b0,`d`}: `r` = `t` − `d` and the shifted-in quotient bit is 1.
  - Otherwise: `r` = `t` and the bit is 0.
  - `q` = {`q`[WIDTH-2:0], bit}; `cnt` += 1.
- The step with `cnt` == WIDTH−1 is the last one. On that edge:
  - Go to DONE.
  - Load `quotient` with the final `q` and `remainder` with the final `r`[WIDTH-1:0].
  - Set `complete`=1, `divide_by_0`=0.
- BUSY with `hold`=1: all internal registers and outputs keep their values.
- `quotient` and `remainder` change only on entry to DONE or on `rst`. During BUSY they hold the previous result.
- DONE and IDLE with no `start`: all outputs hold.
- Result invariant: `a` == `quotient`·`b` + `remainder` and `remainder` < `b`, for every `b` != 0.

## Timing
- Reset: `rst` high at an edge forces the state to IDLE on that edge. All outputs become 0 (`busy`, `complete`, `divide_by_0`, `quotient`, `remainder`), as do `cnt`, `r`, `q` and `d`.
  - `rst` overrides a simultaneous `start`.
  - A reset mid-division discards the operation.
- Accept edge E0 with `b` != 0:
  - `busy` is high from E0 until E_WIDTH.
  - `complete` is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the cycle in which `start` was high (33 for WIDTH=32).
  - Each `hold` cycle inside BUSY adds one cycle.
- Accept edge E0 with `b` == 0: `complete`=1 and `divide_by_0`=1 in the cycle immediately after E0 (1-cycle latency). `busy` never rises.
- A `start` held high for several cycles restarts on every edge. The requester must pulse it for exactly one cycle.
- `start` on the same edge as the final step: the new operation wins. `complete` stays 0 and the old result is not loaded.
- `complete` falls on the edge after an accepted `start`, so a requester checking `complete && !start` never sees a stale result.

## Test plan
- Divide 100 by 7 (`a`=100, `b`=7) with a 1-cycle `start` -> `busy` high for 32 cycles; `complete`=1 at cycle 33; `quotient`=14, `remainder`=2, `divide_by_0`=0.
- Divide all-ones by 1 (`a`=32'hFFFFFFFF, `b`=1), then `a`=32'h80000000, `b`=32'hFFFFFFFF -> first result `quotient`=32'hFFFFFFFF, `remainder`=0. Second result `quotient`=0, `remainder`=32'h80000000.
- Divide by zero (`a`=5, `b`=0) -> next cycle `complete`=1, `divide_by_0`=1, `quotient`=32'hFFFFFFFF, `remainder`=5, `busy` never high.
- Hold stall (`a`=1000, `b`=3) with `hold`=1 for 3 cycles mid-BUSY -> `complete` at cycle 36; `quotient`=333, `remainder`=1.
- Restart and reset:
  - Start `a`=50, `b`=6; at cycle 10 start `a`=81, `b`=9 -> only the second result appears, `quotient`=9, `remainder`=0, 33 cycles after the second start.
  - Separate run with `rst` asserted at cycle 20 -> all outputs 0 and state IDLE the next cycle.
- Random regression: 10k random `a`/`b` pairs, including `b`=0 and `b`>`a` -> `quotient`/`remainder` match `a`/`b` and `a`%`b` (with the zero-divisor values above), checked against the latency rules.
